// File: rtl/mem_byte_initiator.sv
// Byte-serial data-memory initiator: splits one MEM-stage load/store into single-byte
// request/acknowledge transactions, little-endian, and reassembles/extends load data.
module mem_byte_initiator #(
  parameter bit          ALIGN_CHECK = 1'b1,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  input  logic [5:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  localparam logic [7:0] TimeoutCycles = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StXfer, StDone, StErr} state_e;

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [15:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  count_q, count_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] lanes_q, lanes_d;
  logic [31:0] rdata_q, rdata_d;

  // Index of the final byte for a given op[1:0] size code.
  function automatic logic [1:0] last_index(input logic [1:0] sz);
    unique case (sz)
      2'b01:   last_index = 2'd1;
      2'b11:   last_index = 2'd3;
      default: last_index = 2'd0;
    endcase
  endfunction

  logic        req_is_mem;
  logic        req_misaligned;
  logic        cur_store;
  logic [1:0]  cur_last;
  logic [31:0] assembled;
  logic [31:0] extended;

  always_comb begin
    req_is_mem = 1'b0;
    case (req_op)
      6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011,
      6'b101000, 6'b101001, 6'b101011: req_is_mem = 1'b1;
      default:                         req_is_mem = 1'b0;
    endcase
    req_misaligned = ALIGN_CHECK &&
                     (((req_op[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_op[1:0] == 2'b11) && (req_addr[1:0] != 2'b00)));
  end

  assign cur_store = op_q[3];
  assign cur_last  = last_index(op_q[1:0]);

  // Current byte merged into the captured lanes, so the final byte needs no extra cycle.
  always_comb begin
    assembled = lanes_q;
    assembled[{count_q, 3'b000} +: 8] = mem_rdata;
    unique case (op_q[1:0])
      2'b00:   extended = op_q[2] ? {24'h0, assembled[7:0]}
                                  : {{24{assembled[7]}}, assembled[7:0]};
      2'b01:   extended = op_q[2] ? {16'h0, assembled[15:0]}
                                  : {{16{assembled[15]}}, assembled[15:0]};
      default: extended = assembled;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    timer_d   = timer_q;
    lanes_d   = lanes_q;
    rdata_d   = rdata_q;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_is_mem) begin
          if (req_misaligned) begin
            state_d = StErr;
          end else begin
            state_d = StXfer;
            op_d    = req_op;
            base_d  = req_addr;
            wdata_d = req_wdata;
            count_d = 2'd0;
            timer_d = 8'd0;
            lanes_d = 32'h0;
          end
        end
      end
      StXfer: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = cur_store;
        mem_addr  = base_q + {14'h0, count_q};
        mem_wdata = wdata_q[{count_q, 3'b000} +: 8];
        if (mem_ack) begin
          if (!cur_store) lanes_d = assembled;
          if (count_q == cur_last) begin
            state_d = StDone;
            if (!cur_store) rdata_d = extended;
          end else begin
            count_d = count_q + 2'd1;
            timer_d = 8'd0;
          end
        end else if (timer_q + 8'd1 == TimeoutCycles) begin
          state_d = StErr;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        busy    = 1'b1;
        err     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rdata = rdata_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      op_q    <= 6'h00;
      base_q  <= 16'h0000;
      wdata_q <= 32'h0;
      count_q <= 2'd0;
      timer_q <= 8'd0;
      lanes_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      timer_q <= timer_d;
      lanes_q <= lanes_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_byte_initiator.sv
// Directed bench for mem_byte_initiator: behavioural byte memory with programmable ack delay,
// a scoreboard of expected completions and a log of observed byte transactions.
`timescale 1ns/1ps
module tb_mem_byte_initiator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0]  op;
  logic [15:0] addr;
  logic [31:0] wdata;

  logic        a_valid, a_busy, a_done, a_err, a_mem_req, a_mem_we, a_ack;
  logic [31:0] a_rdata;
  logic [15:0] a_mem_addr;
  logic [7:0]  a_mem_wdata, a_mem_rdata;

  logic        b_valid, b_busy, b_done, b_err, b_mem_req, b_mem_we, b_ack;
  logic [31:0] b_rdata;
  logic [15:0] b_mem_addr;
  logic [7:0]  b_mem_wdata, b_mem_rdata;

  mem_byte_initiator #(.ALIGN_CHECK(1'b1), .TIMEOUT(15)) dut (
    .CLK(clk), .RST(rst), .req_valid(a_valid), .req_op(op), .req_addr(addr),
    .req_wdata(wdata), .busy(a_busy), .done(a_done), .err(a_err), .rdata(a_rdata),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_ack(a_ack), .mem_rdata(a_mem_rdata)
  );

  mem_byte_initiator #(.ALIGN_CHECK(1'b0), .TIMEOUT(15)) dut_na (
    .CLK(clk), .RST(rst), .req_valid(b_valid), .req_op(op), .req_addr(addr),
    .req_wdata(wdata), .busy(b_busy), .done(b_done), .err(b_err), .rdata(b_rdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_ack(b_ack), .mem_rdata(b_mem_rdata)
  );

  typedef struct packed {logic we; logic [15:0] addr; logic [7:0] data;} xact_t;
  typedef struct {bit is_err; logic [31:0] rdata;} exp_t;

  logic [7:0] mem [0:65535];
  xact_t a_log[$];
  xact_t exp_log[$];
  logic [15:0] b_log[$];
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_delay = 0;
  bit ack_en = 1'b1;
  int wait_cnt = 0;
  int last_ack_cyc = 0;
  int req_cycles = 0;
  int busy_low = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Memory responder for the aligned-checking instance.
  always @(negedge clk) begin
    xact_t x;
    if (a_mem_req) begin
      req_cycles++;
      if (ack_en && wait_cnt >= ack_delay) begin
        a_ack = 1'b1;
        a_mem_rdata = a_mem_we ? 8'h00 : mem[a_mem_addr];
        if (a_mem_we) mem[a_mem_addr] = a_mem_wdata;
        x.we = a_mem_we;
        x.addr = a_mem_addr;
        x.data = a_mem_we ? a_mem_wdata : 8'h00;
        a_log.push_back(x);
        last_ack_cyc = cyc;
        wait_cnt = 0;
      end else begin
        a_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      a_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (b_mem_req) begin
      b_ack = 1'b1;
      b_mem_rdata = mem[b_mem_addr];
      b_log.push_back(b_mem_addr);
    end else begin
      b_ack = 1'b0;
    end
  end

  // Scoreboard: every done/err pulse pops one expected completion.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && (a_done || a_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_completion", {30'h0, a_done, a_err}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("completion_kind", {30'h0, a_done, a_err}, mon_e.is_err ? 32'h1 : 32'h2);
        chk("completion_rdata", a_rdata, mon_e.rdata);
      end
    end
  end

  task automatic push_exp(input bit is_err, input logic [31:0] r);
    exp_t e;
    e.is_err = is_err;
    e.rdata = r;
    sb.push_back(e);
  endtask

  task automatic push_xact(input logic we, input logic [15:0] ad, input logic [7:0] d);
    xact_t x;
    x.we = we;
    x.addr = ad;
    x.data = d;
    exp_log.push_back(x);
  endtask

  task automatic compare_log(input string tag);
    chk({tag, "_count"}, a_log.size(), exp_log.size());
    for (int i = 0; i < a_log.size() && i < exp_log.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {7'h0, a_log[i]}, {7'h0, exp_log[i]});
    a_log.delete();
    exp_log.delete();
  endtask

  task automatic issue_a(input logic [5:0] o, input logic [15:0] ad, input logic [31:0] wd);
    @(negedge clk);
    op = o;
    addr = ad;
    wdata = wd;
    a_valid = 1'b1;
    @(posedge clk);
    #1 a_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int max);
    int n = 0;
    busy_low = 0;
    do begin
      @(negedge clk);
      n++;
      if (!a_busy) busy_low++;
    end while (!(a_done || a_err) && n < max);
    if (!(a_done || a_err)) chk({tag, "_no_completion"}, 32'h0, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    op = 6'h00;
    addr = 16'h0;
    wdata = 32'h0;
    a_ack = 1'b0;
    b_ack = 1'b0;
    a_mem_rdata = 8'h00;
    b_mem_rdata = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22; mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
    mem[16'h0005] = 8'h80; mem[16'h0006] = 8'h34; mem[16'h0007] = 8'h92;
    mem[16'hFFFE] = 8'hA1; mem[16'hFFFF] = 8'hB2; mem[16'h0000] = 8'hC3; mem[16'h0001] = 8'hD4;

    repeat (2) @(negedge clk);
    chk("reset_ctrl", {27'h0, a_busy, a_done, a_err, a_mem_req, a_mem_we}, 32'h0);
    chk("reset_rdata", a_rdata, 32'h0);
    chk("reset_mem_bus", {8'h0, a_mem_addr, a_mem_wdata}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ctrl", {27'h0, a_busy, a_done, a_err, a_mem_req, a_mem_we}, 32'h0);

    // lw, ack every cycle
    push_exp(1'b0, 32'h44332211);
    for (int i = 0; i < 4; i++) push_xact(1'b0, 16'h0010 + 16'(i), 8'h00);
    issue_a(6'b100011, 16'h0010, 32'h0);
    wait_end("lw", 20);
    chk("lw_done_latency", cyc - last_ack_cyc, 32'd1);
    compare_log("lw");

    push_exp(1'b0, 32'hFFFFFF80);
    push_xact(1'b0, 16'h0005, 8'h00);
    issue_a(6'b100000, 16'h0005, 32'h0);
    wait_end("lb", 20);
    compare_log("lb");

    push_exp(1'b0, 32'h00000080);
    push_xact(1'b0, 16'h0005, 8'h00);
    issue_a(6'b100100, 16'h0005, 32'h0);
    wait_end("lbu", 20);
    compare_log("lbu");

    push_exp(1'b0, 32'hFFFF9234);
    push_xact(1'b0, 16'h0006, 8'h00);
    push_xact(1'b0, 16'h0007, 8'h00);
    issue_a(6'b100001, 16'h0006, 32'h0);
    wait_end("lh", 20);
    compare_log("lh");

    // sh with three wait cycles per byte; rdata must keep the last load value
    ack_delay = 3;
    push_exp(1'b0, 32'hFFFF9234);
    push_xact(1'b1, 16'h0002, 8'hEF);
    push_xact(1'b1, 16'h0003, 8'hBE);
    issue_a(6'b101001, 16'h0002, 32'h1234BEEF);
    wait_end("sh", 40);
    chk("sh_busy_held", busy_low, 32'd0);
    compare_log("sh");
    ack_delay = 0;

    // misaligned lw
    req_cycles = 0;
    push_exp(1'b1, 32'hFFFF9234);
    issue_a(6'b100011, 16'h0002, 32'h0);
    wait_end("misalign", 10);
    @(negedge clk);
    chk("misalign_err_one_cycle", {30'h0, a_err, a_busy}, 32'h0);
    chk("misalign_no_mem_req", req_cycles, 32'd0);

    // sw with no ack: timeout
    ack_en = 1'b0;
    req_cycles = 0;
    push_exp(1'b1, 32'hFFFF9234);
    issue_a(6'b101011, 16'h0020, 32'hCAFEF00D);
    wait_end("sw_timeout", 40);
    chk("sw_timeout_req_cycles", req_cycles, 32'd15);
    @(negedge clk);
    chk("sw_timeout_idle", {30'h0, a_mem_req, a_busy}, 32'h0);
    ack_en = 1'b1;
    a_log.delete();

    push_exp(1'b0, 32'h00000011);
    push_xact(1'b0, 16'h0010, 8'h00);
    issue_a(6'b100000, 16'h0010, 32'h0);
    wait_end("lb_after_timeout", 20);
    compare_log("lb_after_timeout");

    // reset during the second byte of lw
    ack_delay = 2;
    begin
      int n = 0;
      issue_a(6'b100011, 16'h0010, 32'h0);
      while (a_log.size() < 1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("rst_first_byte_seen", a_log.size(), 32'd1);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", {27'h0, a_busy, a_done, a_err, a_mem_req, a_mem_we}, 32'h0);
    chk("rst_mid_rdata", a_rdata, 32'h0);
    chk("rst_mid_mem_bus", {8'h0, a_mem_addr, a_mem_wdata}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_after_quiet%0d", i), {29'h0, a_busy, a_done, a_err}, 32'h0);
    end
    ack_delay = 0;
    a_log.delete();

    push_exp(1'b0, 32'hFFFFFF80);
    push_xact(1'b0, 16'h0005, 8'h00);
    issue_a(6'b100000, 16'h0005, 32'h0);
    wait_end("lb_after_rst", 20);
    compare_log("lb_after_rst");

    // Unchecked instance: lw wrapping past 0xFFFF
    b_log.delete();
    @(negedge clk);
    op = 6'b100011;
    addr = 16'hFFFE;
    wdata = 32'h0;
    b_valid = 1'b1;
    @(posedge clk);
    #1 b_valid = 1'b0;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(b_done || b_err) && n < 20);
    end
    chk("wrap_done", {30'h0, b_done, b_err}, 32'h2);
    chk("wrap_rdata", b_rdata, 32'hD4C3B2A1);
    chk("wrap_count", b_log.size(), 32'd4);
    if (b_log.size() == 4) begin
      chk("wrap_addr0", {16'h0, b_log[0]}, 32'hFFFE);
      chk("wrap_addr1", {16'h0, b_log[1]}, 32'hFFFF);
      chk("wrap_addr2", {16'h0, b_log[2]}, 32'h0000);
      chk("wrap_addr3", {16'h0, b_log[3]}, 32'h0001);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
